byte_write_buffer: RTL and testbench

BYTE_WRITE_BUFFER -- requirements
Module: byte_write_buffer

---
 rtl/byte_write_buffer.sv | 102 ++++++++++
 tb/tb_byte_write_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_write_buffer.sv
// Byte write buffer: a small FIFO between a byte-serialiser and a
// write-only target. Reads are unsupported and only flagged.
module byte_write_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in_address,
  input  logic [7:0]               in_wr_data,
  input  logic                     in_wr,
  input  logic                     in_rd,
  output logic [7:0]               in_rd_data,
  output logic [31:0]              out_address,
  output logic [7:0]               out_wr_data,
  output logic                     out_req,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow,
  output logic                     rd_error,
  input  logic                     err_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [39:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          rde_q, rde_d;

  logic          full;
  logic          has_head;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake decode; a pop frees the slot a same-cycle write lands in.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    has_head = (count_q != '0);
    pop      = has_head && out_ack;
    push     = in_wr && (!full || pop);
    drop     = in_wr && full && !pop;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = drop  || (ovf_q && !err_clear);
    rde_d = in_rd || (rde_q && !err_clear);
  end

  // Control state register; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rde_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rde_q    <= rde_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= {in_address, in_wr_data};
    end
  end

  assign out_address = mem_q[rd_ptr_q][39:8];
  assign out_wr_data = mem_q[rd_ptr_q][7:0];
  assign out_req     = has_head;
  assign count       = count_q;
  assign empty       = !has_head;
  assign overflow    = ovf_q;
  assign rd_error    = rde_q;
  assign in_rd_data  = 8'h00;

endmodule

// File: tb/tb_byte_write_buffer.sv
// Bench for byte_write_buffer: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_byte_write_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic [31:0] in_address;
  logic [7:0]  in_wr_data;
  logic        in_wr;
  logic        in_rd;
  logic [7:0]  in_rd_data;
  logic [31:0] out_address;
  logic [7:0]  out_wr_data;
  logic        out_req;
  logic        out_ack;
  logic [3:0]  count;
  logic        empty;
  logic        overflow;
  logic        rd_error;
  logic        err_clear;

  byte_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_address  (in_address),
    .in_wr_data  (in_wr_data),
    .in_wr       (in_wr),
    .in_rd       (in_rd),
    .in_rd_data  (in_rd_data),
    .out_address (out_address),
    .out_wr_data (out_wr_data),
    .out_req     (out_req),
    .out_ack     (out_ack),
    .count       (count),
    .empty       (empty),
    .overflow    (overflow),
    .rd_error    (rd_error),
    .err_clear   (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [39:0] mq [$];
  logic        m_ovf = 1'b0;
  logic        m_rde = 1'b0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        ack;
    logic        rd;
    logic        clr;
    int          ecnt;
    logic        ereq;
    logic        eovf;
    logic        erde;
    logic [31:0] eaddr;
    logic [7:0]  edata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_req", 64'(out_req), 64'(mq.size() != 0));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("rd_error", 64'(rd_error), 64'(m_rde));
    chk("in_rd_data", 64'(in_rd_data), 64'h0);
    if (mq.size() != 0) begin
      chk("out_address", 64'(out_address), 64'(mq[0][39:8]));
      chk("out_wr_data", 64'(out_wr_data), 64'(mq[0][7:0]));
    end
  endtask

  task automatic step(input logic r, input logic wr,
                      input logic [31:0] a, input logic [7:0] d,
                      input logic ack, input logic rd,
                      input logic clr);
    logic        p;
    logic        f;
    logic        acc;
    logic [39:0] tmp;
    reset      = r;
    in_wr      = wr;
    in_address = a;
    in_wr_data = d;
    out_ack    = ack;
    in_rd      = rd;
    err_clear  = clr;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_rde = 1'b0;
    end else begin
      p   = (mq.size() != 0) && ack;
      f   = (mq.size() == DEPTH);
      acc = wr && (!f || p);
      if (p) tmp = mq.pop_front();
      if (acc) mq.push_back({a, d});
      m_ovf = (wr && !acc) || (m_ovf && !clr);
      m_rde = rd || (m_rde && !clr);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle(input logic ack);
    step(1'b0, 1'b0, 32'h0, 8'h0, ack, 1'b0, 1'b0);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [7:0] d,
                     input logic ack);
    step(1'b0, 1'b1, a, d, ack, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_rd = 1'b0; out_ack = 1'b0;
    err_clear = 1'b0; in_address = '0; in_wr_data = '0;

    do_reset();
    do_reset();
    chk("rst_req", 64'(out_req), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    chk("rst_count", 64'(count), 64'h0);

    tbl[0] = '{0,1,32'h200,8'hA0,0,0,0, 1,1,0,0,32'h200,8'hA0};
    tbl[1] = '{0,1,32'h201,8'hA1,0,0,0, 2,1,0,0,32'h200,8'hA0};
    tbl[2] = '{0,0,32'h0,8'h0,0,1,0,    2,1,0,1,32'h200,8'hA0};
    tbl[3] = '{0,0,32'h0,8'h0,0,1,1,    2,1,0,1,32'h200,8'hA0};
    tbl[4] = '{0,0,32'h0,8'h0,0,0,1,    2,1,0,0,32'h200,8'hA0};
    tbl[5] = '{0,0,32'h0,8'h0,1,0,0,    1,1,0,0,32'h201,8'hA1};
    tbl[6] = '{0,1,32'h202,8'hA2,1,0,0, 1,1,0,0,32'h202,8'hA2};
    tbl[7] = '{0,0,32'h0,8'h0,1,0,0,    0,0,0,0,32'h0,8'h0};
    tbl[8] = '{0,0,32'h0,8'h0,1,0,0,    0,0,0,0,32'h0,8'h0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].a, tbl[i].d,
           tbl[i].ack, tbl[i].rd, tbl[i].clr);
      chk("tbl_count", 64'(count), 64'(tbl[i].ecnt));
      chk("tbl_req", 64'(out_req), 64'(tbl[i].ereq));
      chk("tbl_ovf", 64'(overflow), 64'(tbl[i].eovf));
      chk("tbl_rderr", 64'(rd_error), 64'(tbl[i].erde));
      if (tbl[i].ereq) begin
        chk("tbl_addr", 64'(out_address), 64'(tbl[i].eaddr));
        chk("tbl_data", 64'(out_wr_data), 64'(tbl[i].edata));
      end
    end

    // Scenario 1: streaming with ack tied high.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr1(32'h100 + 32'(i), 8'h11 * 8'(i + 1), 1'b1);
      chk("s1_req", 64'(out_req), 64'h1);
      chk("s1_cnt_le1", 64'(count <= 4'd1), 64'h1);
      chk("s1_data", 64'(out_wr_data), 64'(8'h11 * 8'(i + 1)));
    end
    idle(1'b1);
    chk("s1_req_end", 64'(out_req), 64'h0);

    // Scenario 2: overflow on the ninth write, then drain in order.
    do_reset();
    for (int i = 0; i < 9; i++) wr1(32'h300 + 32'(i), 8'(i + 1), 1'b0);
    chk("s2_count", 64'(count), 64'd8);
    chk("s2_ovf", 64'(overflow), 64'h1);
    for (int i = 0; i < 8; i++) begin
      chk("s2_order", 64'(out_wr_data), 64'(i + 1));
      idle(1'b1);
    end
    chk("s2_empty", 64'(empty), 64'h1);

    // Scenario 3: write and pop together while full.
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) wr1(32'h400 + 32'(i), 8'(8'h40 + i), 1'b0);
    wr1(32'h4FF, 8'hEE, 1'b1);
    chk("s3_count", 64'(count), 64'd8);
    chk("s3_ovf", 64'(overflow), 64'h0);
    for (int i = 0; i < 7; i++) idle(1'b1);
    chk("s3_last_addr", 64'(out_address), 64'h4FF);
    chk("s3_last_data", 64'(out_wr_data), 64'hEE);
    idle(1'b1);

    // Scenario 4: head stays stable while stalled.
    for (int i = 0; i < 3; i++) wr1(32'h500 + 32'(i), 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("s4_hold_a", 64'(out_address), 64'h500);
      chk("s4_hold_d", 64'(out_wr_data), 64'h50);
    end
    idle(1'b1);
    chk("s4_next_a", 64'(out_address), 64'h501);
    chk("s4_next_d", 64'(out_wr_data), 64'h51);

    // Scenario 5: reset discards buffered entries and a write in reset.
    do_reset();
    for (int i = 0; i < 5; i++) wr1(32'h600 + 32'(i), 8'(i), 1'b0);
    step(1'b1, 1'b1, 32'hDEAD, 8'hDD, 1'b1, 1'b0, 1'b0);
    chk("s5_req", 64'(out_req), 64'h0);
    chk("s5_count", 64'(count), 64'h0);
    wr1(32'h700, 8'h77, 1'b0);
    chk("s5_first_a", 64'(out_address), 64'h700);
    chk("s5_first_d", 64'(out_wr_data), 64'h77);

    // Scenario 6: rd_error set wins over clear.
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
    chk("s6_rde", 64'(rd_error), 64'h1);
    chk("s6_cnt", 64'(count), 64'h1);
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b1);
    chk("s6_rde_win", 64'(rd_error), 64'h1);
    step(1'b0, 1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
    chk("s6_rde_clr", 64'(rd_error), 64'h0);

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           1'($urandom_range(0, 1)),
           $urandom, 8'($urandom),
           $urandom_range(0, 99) < 45,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
